// File: rtl/aes_inv_pkg.sv
// Shared types, constants and GF(2^8)/AES helper functions for the
// iterative AES-128 inverse cipher.
package aes_inv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEXP = 2'd1,
        ST_DEC  = 2'd2
    } inv_state_e;

    // Round constants indexed by round number 1..10; other slots are unused.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] gmul_9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] gmul_b(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] gmul_d(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] gmul_e(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    // Forward S-box: inverse followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform followed by the field inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_step_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Recovers rk_r from rk_{r+1}; rc is Rcon[r+1].
    function automatic logic [127:0] key_step_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    // Byte s(r,c) lives at bits [127-8*(4c+r) -: 8].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul_e(a0) ^ gmul_b(a1) ^ gmul_d(a2) ^ gmul_9(a3);
            o[119 - 32*c -: 8] = gmul_9(a0) ^ gmul_e(a1) ^ gmul_b(a2) ^ gmul_d(a3);
            o[111 - 32*c -: 8] = gmul_d(a0) ^ gmul_9(a1) ^ gmul_e(a2) ^ gmul_b(a3);
            o[103 - 32*c -: 8] = gmul_b(a0) ^ gmul_d(a1) ^ gmul_9(a2) ^ gmul_e(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// One inverse AES round, purely combinational:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped on last).
module aes_inv_round_comb
    import aes_inv_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;

    // Round datapath; the final round leaves out InvMixColumns.
    always_comb begin
        shifted = inv_shift_rows(state_i);
        subbed  = '0;
        for (int i = 0; i < 16; i++) begin
            subbed[127 - 8*i -: 8] = inv_sbox(shifted[127 - 8*i -: 8]);
        end
        keyed   = subbed ^ rk_i;
        state_o = last_i ? keyed : inv_mix_columns(keyed);
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor: 10 forward key-schedule steps to reach rk10,
// then 10 inverse rounds while walking the key schedule backwards.
module aes_inv_cipher_iter
    import aes_inv_pkg::*;
#(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             AES_clk,
    input  logic             AES_rst,
    input  logic             AES_inv_en,
    input  logic [KEY_W-1:0] AES_inv_data_in,
    input  logic [KEY_W-1:0] AES_inv_key_in,
    output logic             AES_inv_busy,
    output logic [KEY_W-1:0] AES_inv_data_out,
    output logic             AES_inv_data_out_valid
);

    if (NR != 10 || KEY_W != 128) begin : g_bad_param
        $error("aes_inv_cipher_iter supports only AES-128 (NR=10, KEY_W=128)");
    end

    localparam logic [3:0] LAST_KEXP = 4'(NR);
    localparam logic [3:0] FIRST_DEC = 4'(NR - 1);

    inv_state_e   st_q, st_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   rc_q, rc_d;
    logic [127:0] dout_q, dout_d;
    logic         valid_q, valid_d;

    logic [127:0] key_fwd;
    logic [127:0] key_inv;
    logic [127:0] round_out;

    assign key_fwd = key_step_fwd(key_q, RCON[rc_q]);
    assign key_inv = key_step_inv(key_q, RCON[rc_q + 4'd1]);

    aes_inv_round_comb u_round (
        .state_i (state_q),
        .rk_i    (key_inv),
        .last_i  (rc_q == 4'd0),
        .state_o (round_out)
    );

    // Next-state logic: capture in IDLE, expand key in KEXP, decrypt in DEC.
    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        key_d   = key_q;
        rc_d    = rc_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (AES_inv_en) begin
                    state_d = AES_inv_data_in;
                    key_d   = AES_inv_key_in;
                    rc_d    = 4'd1;
                    st_d    = ST_KEXP;
                end
            end
            ST_KEXP: begin
                key_d = key_fwd;
                rc_d  = rc_q + 4'd1;
                if (rc_q == LAST_KEXP) begin
                    // Initial AddRoundKey uses rk10 as it is being formed.
                    state_d = state_q ^ key_fwd;
                    rc_d    = FIRST_DEC;
                    st_d    = ST_DEC;
                end
            end
            ST_DEC: begin
                state_d = round_out;
                key_d   = key_inv;
                rc_d    = rc_q - 4'd1;
                if (rc_q == 4'd0) begin
                    dout_d  = round_out;
                    valid_d = 1'b1;
                    rc_d    = 4'd0;
                    st_d    = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any operation without a valid pulse.
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            st_q    <= ST_IDLE;
            state_q <= '0;
            key_q   <= '0;
            rc_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign AES_inv_busy           = (st_q != ST_IDLE);
    assign AES_inv_data_out       = dout_q;
    assign AES_inv_data_out_valid = valid_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 vectors, back-to-back, reset abort,
// and random loopback through a bench-local forward AES model.
module tb_aes_inv_cipher_iter;

    logic         clk;
    logic         rst;
    logic         en;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         busy;
    logic [127:0] data_out;
    logic         valid;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [127:0] exp_q[$];
    logic [7:0]   tb_sbox [256];

    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;

    aes_inv_cipher_iter dut (
        .AES_clk                (clk),
        .AES_rst                (rst),
        .AES_inv_en             (en),
        .AES_inv_data_in        (data_in),
        .AES_inv_key_in         (key_in),
        .AES_inv_busy           (busy),
        .AES_inv_data_out       (data_out),
        .AES_inv_data_out_valid (valid)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- bench-local forward AES model ----------------
    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] x;
        for (int v = 0; v < 256; v++) begin
            x   = 8'(v);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (tb_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
            tb_sbox[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                       ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] tb_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tb_sbox[tmp[23:16]], tb_sbox[tmp[15:8]], tb_sbox[tmp[7:0]],
                       tb_sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = tb_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) t[i] = tb_sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c + r] = t[4*((c + r) % 4) + r];
            if (rd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = tb_mul(a0, 8'h02) ^ tb_mul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ tb_mul(a1, 8'h02) ^ tb_mul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ tb_mul(a2, 8'h02) ^ tb_mul(a3, 8'h03);
                    s[4*c+3] = tb_mul(a0, 8'h03) ^ a1 ^ a2 ^ tb_mul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31 - 8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: every valid pulse pops one expected plaintext.
    always @(negedge clk) begin
        if (valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 128'd1, 128'd0);
            end else begin
                check("data_out", data_out, exp_q.pop_front());
            end
        end
    end

    // Driver: one single-pulse operation with latency/busy checks.
    task automatic run_op(input logic [127:0] key, input logic [127:0] ct,
                          input logic [127:0] pt, input bit check_rk);
        int cyc;
        int busy_bad;
        @(negedge clk);
        key_in  = key;
        data_in = ct;
        en      = 1'b1;
        @(posedge clk);
        #1;
        en      = 1'b0;
        data_in = rand128();
        key_in  = rand128();
        exp_q.push_back(pt);
        cyc      = 0;
        busy_bad = 0;
        while (!valid && cyc < 40) begin
            if (busy !== 1'b1) busy_bad++;
            if (check_rk && cyc == 10) check("key_reg_rk10", dut.key_q, C1_RK10);
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", 128'(cyc), 128'd20);
        check("busy_window", 128'(busy_bad), 128'd0);
        check("busy_after_valid", 128'(busy), 128'd0);
        @(posedge clk);
        #1;
        check("valid_one_cycle", 128'(valid), 128'd0);
        check("data_out_hold", data_out, pt);
    endtask

    // Directed sequence
    initial begin
        int n_idle;
        logic [127:0] k;
        logic [127:0] p;
        rst     = 1'b1;
        en      = 1'b0;
        data_in = '0;
        key_in  = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_valid", 128'(valid), 128'd0);
        check("rst_data_out", data_out, 128'd0);
        check("rst_key_reg", dut.key_q, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // FIPS-197 C.1 and B
        run_op(C1_KEY, C1_CT, C1_PT, 1'b1);
        run_op(B_KEY, B_CT, B_PT, 1'b0);

        // Back-to-back with en held high; inputs disturbed at E5
        @(negedge clk);
        key_in  = C1_KEY;
        data_in = C1_CT;
        en      = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(C1_PT);
        for (int cyc = 1; cyc <= 41; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 5) begin
                data_in = rand128();
                key_in  = rand128();
            end
            if (cyc == 20) begin
                check("b2b_valid_first", 128'(valid), 128'd1);
                data_in = B_CT;
                key_in  = B_KEY;
                exp_q.push_back(B_PT);
            end
            if (cyc == 21) begin
                en = 1'b0;
                check("b2b_reaccept_busy", 128'(busy), 128'd1);
            end
            if (cyc == 41) check("b2b_valid_second", 128'(valid), 128'd1);
        end
        @(posedge clk);
        #1;

        // Reset at E12 during DEC
        @(negedge clk);
        key_in  = C1_KEY;
        data_in = C1_CT;
        en      = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        exp_q.push_back(C1_PT);
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_valid", 128'(valid), 128'd0);
        check("abort_data_out", data_out, 128'd0);
        check("abort_key_reg", dut.key_q, 128'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("abort_no_pulse_data_out", data_out, 128'd0);
        run_op(C1_KEY, C1_CT, C1_PT, 1'b1);

        // Random loopback through the forward model
        for (int n = 0; n < 100; n++) begin
            k = rand128();
            p = rand128();
            run_op(k, tb_encrypt(k, p), p, 1'b0);
            n_idle = $urandom_range(0, 2);
            for (int j = 0; j < n_idle; j++) begin
                @(posedge clk);
                #1;
                check("idle_hold", data_out, p);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
